// File: rtl/ksa_iter_seq.sv
// ksa_iter_seq: iterative Kogge-Stone adder.
// One generic prefix-combine row is reused for NSTAGE passes with distances
// 1, 2, 4, ... WIDTH/2. Operands and results move over valid/ready handshakes.
module ksa_iter_seq #(
    parameter int WIDTH  = 32,
    parameter int NSTAGE = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic [2:0]       stage
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREFIX,
        S_DONE
    } state_t;

    localparam logic [2:0]       LAST_STAGE = 3'(NSTAGE - 1);
    localparam logic [WIDTH-1:0] ONES       = '1;

    state_t           r_state;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_g;
    logic [WIDTH-1:0] r_p0;
    logic [WIDTH-1:0] r_sum;
    logic             r_cin;
    logic             r_cout;
    logic [2:0]       r_stage;

    logic [7:0]       w_dist;
    logic [WIDTH-1:0] w_g_next;
    logic [WIDTH-1:0] w_p_next;
    logic [WIDTH-1:0] w_p_new;
    logic [WIDTH-1:0] w_g_new;
    logic             w_accept;

    // Ready depends only on state and out_ready, never on in_valid
    assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_PREFIX);
    assign stage     = r_stage;
    assign sum       = r_sum;
    assign cout      = r_cout;

    // Generate/propagate terms of the incoming operands, carry-in folded into bit 0
    always_comb begin
        w_p_new    = a ^ b;
        w_g_new    = a & b;
        w_g_new[0] = (a[0] & b[0]) | (w_p_new[0] & cin);
    end

    // One prefix row at distance 2**stage; shifted-in zeros leave the low lanes unchanged
    always_comb begin
        w_dist   = 8'd1 << r_stage;
        w_g_next = r_g | (r_p & (r_g << w_dist));
        w_p_next = r_p & ((r_p << w_dist) | ~(ONES << w_dist));
    end

    // Control FSM with working P/G, saved p0 and registered result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_p     <= '0;
            r_g     <= '0;
            r_p0    <= '0;
            r_sum   <= '0;
            r_cin   <= 1'b0;
            r_cout  <= 1'b0;
            r_stage <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_p     <= w_p_new;
                        r_p0    <= w_p_new;
                        r_g     <= w_g_new;
                        r_cin   <= cin;
                        r_stage <= '0;
                        r_state <= S_PREFIX;
                    end else if ((r_state == S_DONE) && out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                S_PREFIX: begin
                    r_g <= w_g_next;
                    r_p <= w_p_next;
                    if (r_stage == LAST_STAGE) begin
                        // Final carries come straight from this pass's row output
                        r_sum   <= r_p0 ^ {w_g_next[WIDTH-2:0], r_cin};
                        r_cout  <= w_g_next[WIDTH-1];
                        r_state <= S_DONE;
                    end else begin
                        r_stage <= r_stage + 3'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
